// File: rtl/test_status_pkg.sv
// Shared state encoding, register map and command codes for the test-status peripheral.
package lexington;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DONE    = 2'd1,
    ST_FAILED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } test_state_t;

  localparam logic [4:0] OFF_STATUS  = 5'h00;
  localparam logic [4:0] OFF_CHECK_A = 5'h04;
  localparam logic [4:0] OFF_CHECK_B = 5'h08;
  localparam logic [4:0] OFF_CHECK   = 5'h0C;
  localparam logic [4:0] OFF_COUNTS  = 5'h10;
  localparam logic [4:0] OFF_FAIL_PC = 5'h14;
  localparam logic [4:0] OFF_CYCLE   = 5'h18;
  localparam logic [4:0] OFF_CMD     = 5'h1C;

  localparam logic [31:0] DEF_DONE_CODE = 32'h0D15EA5E;
  localparam logic [31:0] DEF_FAIL_CODE = 32'hDEADBEEF;

  function automatic logic reg_readable(input logic [4:0] off);
    return !(off == OFF_CHECK || off == OFF_CMD);
  endfunction

  function automatic logic reg_writable(input logic [4:0] off);
    return (off == OFF_CHECK_A) || (off == OFF_CHECK_B) ||
           (off == OFF_CHECK)   || (off == OFF_CMD);
  endfunction

endpackage

// File: rtl/test_status_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/test_status.sv
// Memory-mapped test-status peripheral: check accounting, end-of-test commands,
// run watchdog, sticky halt/pass outputs.
module test_status
  import lexington::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned MAX_CYCLES = 2048,
  parameter logic [31:0] DONE_CODE  = DEF_DONE_CODE,
  parameter logic [31:0] FAIL_CODE  = DEF_FAIL_CODE
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rd_en,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wr_data,
  input  logic [3:0]            i_wr_strobe,
  output logic [31:0]           o_rd_data,
  output logic                  o_access_fault,
  output logic                  o_busy,
  output logic                  o_halt,
  output logic                  o_pass
);

  localparam logic [31:0] LP_CYC_LAST = 32'(MAX_CYCLES - 1);

  test_state_t r_state;
  logic        r_cmd_err;
  logic [31:0] r_check_a;
  logic [31:0] r_check_b;
  logic [31:0] r_fail_pc;
  logic [31:0] r_cycle;
  logic        r_pend_vld;
  logic        r_pend_match;
  logic [31:0] r_pend_pc;

  logic [15:0] w_check_cnt;
  logic [15:0] w_fail_cnt;
  logic [4:0]  w_off;
  logic        w_hi_nz;
  logic        w_wr;
  logic        w_rd;
  logic        w_fault;
  logic        w_we;
  logic        w_timeout;
  logic        w_run;
  logic        w_commit;
  logic        w_commit_fail;
  logic        w_done_ok;
  logic [31:0] w_rd_data;

  assign w_off   = {i_addr[4:2], 2'b00};
  assign w_hi_nz = |(i_addr >> 5);

  // The core holds its access while a check commits, so both strobes are masked.
  assign w_wr = i_wr_en & ~r_pend_vld;
  assign w_rd = i_rd_en & ~i_wr_en & ~r_pend_vld;

  always_comb begin
    w_fault = 1'b0;
    if (w_wr || w_rd) begin
      if ((i_addr[1:0] != 2'b00) || w_hi_nz) w_fault = 1'b1;
      if (w_wr && ((i_wr_strobe != 4'hF) || !reg_writable(w_off))) w_fault = 1'b1;
      if (w_rd && !reg_readable(w_off)) w_fault = 1'b1;
    end
  end

  assign w_we          = w_wr & ~w_fault;
  assign w_timeout     = (r_state == ST_RUN) && (r_cycle == LP_CYC_LAST);
  assign w_run         = (r_state == ST_RUN) && !w_timeout;
  assign w_commit      = r_pend_vld && !w_timeout;
  assign w_commit_fail = w_commit && !r_pend_match;
  assign w_done_ok     = (w_fail_cnt == 16'h0) && !w_commit_fail;

  sat_counter #(.WIDTH(16)) u_check_cnt (
    .i_clk   (i_clk),
    .i_clr   (i_rst),
    .i_inc   (w_commit),
    .o_count (w_check_cnt)
  );

  sat_counter #(.WIDTH(16)) u_fail_cnt (
    .i_clk   (i_clk),
    .i_clr   (i_rst),
    .i_inc   (w_commit_fail),
    .o_count (w_fail_cnt)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_RUN;
      r_cmd_err    <= 1'b0;
      r_check_a    <= '0;
      r_check_b    <= '0;
      r_fail_pc    <= '0;
      r_cycle      <= '0;
      r_pend_vld   <= 1'b0;
      r_pend_match <= 1'b0;
      r_pend_pc    <= '0;
    end else begin
      r_pend_vld <= 1'b0;
      if (w_commit_fail && (w_fail_cnt == 16'h0)) r_fail_pc <= r_pend_pc;
      if (w_run) r_cycle <= r_cycle + 32'd1;
      if (w_timeout) r_state <= ST_TIMEOUT;
      // Terminal states accept these writes without fault but drop them here.
      if (w_we && w_run) begin
        case (w_off)
          OFF_CHECK_A: r_check_a <= i_wr_data;
          OFF_CHECK_B: r_check_b <= i_wr_data;
          OFF_CHECK: begin
            r_pend_vld   <= 1'b1;
            r_pend_match <= (r_check_a == r_check_b);
            r_pend_pc    <= i_wr_data;
          end
          OFF_CMD: begin
            if (i_wr_data == DONE_CODE)      r_state <= w_done_ok ? ST_DONE : ST_FAILED;
            else if (i_wr_data == FAIL_CODE) r_state <= ST_FAILED;
            else                             r_cmd_err <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    if (w_rd && !w_fault) begin
      case (w_off)
        OFF_STATUS:  w_rd_data = {28'd0, r_pend_vld, r_cmd_err, r_state};
        OFF_CHECK_A: w_rd_data = r_check_a;
        OFF_CHECK_B: w_rd_data = r_check_b;
        OFF_COUNTS:  w_rd_data = {w_fail_cnt, w_check_cnt};
        OFF_FAIL_PC: w_rd_data = r_fail_pc;
        OFF_CYCLE:   w_rd_data = r_cycle;
        default:     w_rd_data = '0;
      endcase
    end
  end

  assign o_rd_data      = w_rd_data;
  assign o_access_fault = w_fault;
  assign o_busy         = r_pend_vld;
  assign o_halt         = (r_state != ST_RUN);
  assign o_pass         = (r_state == ST_DONE);

endmodule

// File: doc/test_status.md
# test_status

Memory-mapped test-status peripheral on the core's external data bus (the AXI-window port: rd_en/wr_en/addr/wr_data/wr_strobe in, rd_data/access_fault/busy out). Firmware reports self-check results and end-of-test codes through register writes instead of simulator-only side channels. The block keeps pass/fail accounting and a run watchdog, and drives sticky halt/pass outputs. A bench, or an FPGA LED, consumes those outputs directly.

## Interface
- ADDR_WIDTH, 5: byte-offset width of the register window; must be ≥5.
- MAX_CYCLES, 2048: watchdog limit in clk cycles.
- DONE_CODE, 32'h0D15EA5E: CMD value requesting normal completion.
- FAIL_CODE, 32'hDEADBEEF: CMD value forcing failure.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- rd_en  in  1  read strobe.
- wr_en  in  1  write strobe.
- addr  in  ADDR_WIDTH  byte offset within the block.
- wr_data  in  32  write data.
- wr_strobe  in  4  byte enables.
- rd_data  out  32  read data, combinational from registered state.
- access_fault  out  1  combinational fault for the current access.
- busy  out  1  block is committing a check; the core holds its access.
- halt  out  1  high in any terminal state.
- pass  out  1  high only in DONE.

## Operation
- Register map (word offsets):
  - 0x00 STATUS R: [1:0] state (0 RUN, 1 DONE, 2 FAILED, 3 TIMEOUT); [2] cmd_err; [3] busy.
  - 0x04 CHECK_A RW.
  - 0x08 CHECK_B RW.
  - 0x0C CHECK W.
  - 0x10 COUNTS R: {fail_count[15:0], check_count[15:0]}.
  - 0x14 FAIL_PC R.
  - 0x18 CYCLE R.
  - 0x1C CMD W.
- access_fault conditions (no state change when faulted):
  - addr[1:0]≠0;
  - addr bits above [4:0] nonzero;
  - write with wr_strobe≠4'hF;
  - write to an R register;
  - read of a W register. rd_data=0 on any fault.
- CHECK write: captures (CHECK_A==CHECK_B) and wr_data (caller PC) into a pending stage.
- Commit of a pending check, on the next cycle with busy=1:
  - check_count += 1;
  - on mismatch, fail_count += 1;
  - FAIL_PC loads wr_data only on the first mismatch after reset.
- Counters saturate at 16'hFFFF.
- State machine:
  - RUN → DONE on CMD=DONE_CODE with fail_count==0, including a check committing in the same cycle.
  - RUN → FAILED on CMD=DONE_CODE with nonzero fail_count, or on CMD=FAIL_CODE.
  - RUN → TIMEOUT when CYCLE reaches MAX_CYCLES-1.
  - Any other CMD value sets sticky cmd_err; state unchanged.
- Terminal states are sticky until rst. In a terminal state:
  - CHECK, CHECK_A/B and CMD writes are accepted without fault but ignored;
  - CYCLE freezes.
- CYCLE increments every cycle in RUN.

## Timing
- Reset: all registers, counters, FAIL_PC, CYCLE, cmd_err and pending cleared; state=RUN; halt=pass=busy=0. Reset mid-check discards the pending check.
- Reads: zero-latency, reflecting state after the previous edge.
- Writes: commit on the rising edge with wr_en high.
- CHECK write at cycle N:
  - busy=1 during N+1 only;
  - rd_en/wr_en are ignored while busy;
  - counts are readable at N+2.
- Back-to-back checks: issuing is legal only once busy has dropped, so throughput is one check per 2 cycles.
- CMD write at cycle N: halt/pass valid at N+1.
- Simultaneous events:
  - TIMEOUT and a CMD in the same cycle: TIMEOUT wins.
  - TIMEOUT and a pending commit in the same cycle: the commit is dropped.
  - rd_en and wr_en both high: treated as a write.

## Structure
- Shared package lexington:
  - test_state_t enum (RUN, DONE, FAILED, TIMEOUT);
  - register offset localparams;
  - DONE_CODE/FAIL_CODE defaults.
- Sub-module sat_counter (WIDTH, inc, clr, count) instantiated for check_count and fail_count.
- CYCLE and the state machine stay inline.

## Test plan
- Write A=5, B=5, CHECK=0x100 → busy for one cycle; COUNTS=0x0000_0001; FAIL_PC=0.
- Write A=5, B=6, CHECK=0x200, then A=1, B=2, CHECK=0x300 → COUNTS=0x0002_0002; FAIL_PC=0x200.
- CMD=0x0D15EA5E after passing checks only → STATUS[1:0]=1; halt=pass=1 next cycle. After one failure → STATUS[1:0]=2; pass=0.
- No CMD for MAX_CYCLES → state TIMEOUT at CYCLE=MAX_CYCLES-1. A CMD in that same cycle is ignored.
- Faults each return access_fault=1 with no state change:
  - write to 0x10;
  - read of 0x1C;
  - addr=0x06;
  - wr_strobe=4'h3.
- CMD=0x12345678 → cmd_err=1, state RUN. Assert rst during a pending check → next cycle all counts 0 and busy=0.
